regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order writeback

---
 rtl/regfile_write_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority over
// queued long-unit results, and a starvation counter forces those results to drain.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_reg_write_w,
  input  logic [ADDR_WIDTH-1:0]      i_write_reg_w,
  input  logic [DATA_WIDTH-1:0]      i_result_w,
  input  logic                       i_long_valid,
  input  logic [ADDR_WIDTH-1:0]      i_long_reg,
  input  logic [DATA_WIDTH-1:0]      i_long_data,
  output logic                       o_long_ready,
  output logic                       o_stall_wb,
  output logic                       o_rf_we_c,
  output logic [ADDR_WIDTH-1:0]      o_rf_wa_c,
  output logic [DATA_WIDTH-1:0]      o_rf_wd_c,
  output logic [2**ADDR_WIDTH-1:0]   o_pending_mask
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam int unsigned NREG  = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [PTR_W:0]          r_wr_ptr;
  logic [PTR_W:0]          r_rd_ptr;
  logic [FIFO_DEPTH-1:0]   r_vld;
  logic [ADDR_WIDTH-1:0]   r_mem_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
  logic                    r_stall;
  logic                    r_long_ready;
  logic [NREG-1:0]         r_pending;

  logic [PTR_W-1:0]        w_rd_idx;
  logic [PTR_W-1:0]        w_wr_idx;
  logic                    w_empty;
  logic                    w_pipe_eff;
  logic                    w_push;
  logic                    w_pop;
  logic [ADDR_WIDTH-1:0]   w_head_reg;
  logic [DATA_WIDTH-1:0]   w_head_data;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_wa;
  logic [DATA_WIDTH-1:0]   w_wd;
  logic [PTR_W:0]          w_wr_ptr_n;
  logic [PTR_W:0]          w_rd_ptr_n;
  logic                    w_full_n;
  logic                    w_empty_n;
  logic [FIFO_DEPTH-1:0]   w_vld_n;
  logic [NREG-1:0]         w_pending_n;

  assign w_rd_idx    = r_rd_ptr[PTR_W-1:0];
  assign w_wr_idx    = r_wr_ptr[PTR_W-1:0];
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_pipe_eff  = i_reg_write_w && (i_write_reg_w != '0);
  assign w_push      = i_long_valid && r_long_ready;
  assign w_head_reg  = r_mem_reg[w_rd_idx];
  assign w_head_data = r_mem_data[w_rd_idx];

  // Write-port grant: forced drain, then pipeline, then idle-cycle drain.
  always_comb begin
    w_pop = 1'b0;
    w_we  = 1'b0;
    w_wa  = '0;
    w_wd  = '0;
    if (!w_empty && (r_stall || !w_pipe_eff)) begin
      w_pop = 1'b1;
      if (w_head_reg != '0) begin
        w_we = 1'b1;
        w_wa = w_head_reg;
        w_wd = w_head_data;
      end
    end else if (w_pipe_eff && !r_stall) begin
      w_we = 1'b1;
      w_wa = i_write_reg_w;
      w_wd = i_result_w;
    end
  end

  // Zero-latency write port, forced quiet while reset is asserted.
  assign o_rf_we_c = rst_n && w_we;
  assign o_rf_wa_c = rst_n ? w_wa : '0;
  assign o_rf_wd_c = rst_n ? w_wd : '0;

  // Next FIFO occupancy, slot validity and pending-register mask.
  always_comb begin
    w_wr_ptr_n = r_wr_ptr + (PTR_W+1)'(w_push);
    w_rd_ptr_n = r_rd_ptr + (PTR_W+1)'(w_pop);
    w_full_n   = (w_wr_ptr_n[PTR_W] != w_rd_ptr_n[PTR_W]) &&
                 (w_wr_ptr_n[PTR_W-1:0] == w_rd_ptr_n[PTR_W-1:0]);
    w_empty_n  = (w_wr_ptr_n == w_rd_ptr_n);
    w_vld_n    = r_vld;
    if (w_pop)  w_vld_n[w_rd_idx] = 1'b0;
    if (w_push) w_vld_n[w_wr_idx] = 1'b1;
    w_pending_n = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (w_vld_n[i]) begin
        if (w_push && (PTR_W'(i) == w_wr_idx)) w_pending_n[i_long_reg]   = 1'b1;
        else                                   w_pending_n[r_mem_reg[i]] = 1'b1;
      end
    end
  end

  // Queue storage; contents are only meaningful under the valid bits.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[w_wr_idx]  <= i_long_reg;
      r_mem_data[w_wr_idx] <= i_long_data;
    end
  end

  // Pointers, registered status outputs and the starvation FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_vld        <= '0;
      r_stall      <= 1'b0;
      r_long_ready <= 1'b1;
      r_pending    <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_n;
      r_rd_ptr     <= w_rd_ptr_n;
      r_vld        <= w_vld_n;
      r_long_ready <= !w_full_n;
      r_pending    <= w_pending_n;
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (w_pop) begin
            r_cnt <= '0;
            if (w_empty_n) r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            r_state <= ST_FORCE;
            r_stall <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FORCE: begin
          // Drained once the read pointer catches the pre-push write pointer.
          if (w_rd_ptr_n == r_wr_ptr) begin
            r_stall <= 1'b0;
            r_cnt   <= '0;
            r_state <= w_push ? ST_WAIT : ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_long_ready   = r_long_ready;
  assign o_stall_wb     = r_stall;
  assign o_pending_mask = r_pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter against a queue-based model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned NR    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_write_w;
  logic [AW-1:0] write_reg_w;
  logic [DW-1:0] result_w;
  logic          long_valid;
  logic [AW-1:0] long_reg;
  logic [DW-1:0] long_data;
  logic          long_ready;
  logic          stall_wb;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [NR-1:0] pending_mask;

  regfile_write_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_reg_write_w  (reg_write_w),
    .i_write_reg_w  (write_reg_w),
    .i_result_w     (result_w),
    .i_long_valid   (long_valid),
    .i_long_reg     (long_reg),
    .i_long_data    (long_data),
    .o_long_ready   (long_ready),
    .o_stall_wb     (stall_wb),
    .o_rf_we_c      (rf_we),
    .o_rf_wa_c      (rf_wa),
    .o_rf_wd_c      (rf_wd),
    .o_pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          stall;
    logic          ready;
    logic [NR-1:0] mask;
  } exp_t;

  exp_t             sb_q[$];
  logic [AW+DW-1:0] mq[$];     // model queue of {reg, data}
  int unsigned      age;       // cycles the head has waited without a pop
  bit               forcing;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NR-1:0] mask_of_q();
    logic [NR-1:0] m;
    logic [AW-1:0] r;
    m = '0;
    foreach (mq[i]) begin
      r = mq[i][AW+DW-1 -: AW];
      m[r] = 1'b1;
    end
    return m;
  endfunction

  // One clock cycle of stimulus; the model predicts this cycle's outputs.
  task automatic cyc(input logic rw, input logic [AW-1:0] wreg, input logic [DW-1:0] res,
                     input logic lv, input logic [AW-1:0] lreg, input logic [DW-1:0] ldata);
    exp_t             e;
    logic [AW+DW-1:0] head;
    bit               pop;
    bit               pipe;
    @(posedge clk);
    #1;
    reg_write_w = rw;  write_reg_w = wreg; result_w  = res;
    long_valid  = lv;  long_reg    = lreg; long_data = ldata;
    e       = '0;
    e.stall = forcing;
    e.ready = (mq.size() < DEPTH);
    e.mask  = mask_of_q();
    pipe    = rw && (wreg != '0);
    pop     = 0;
    if (mq.size() > 0 && (forcing || !pipe)) begin
      head = mq.pop_front();
      pop  = 1;
      if (head[AW+DW-1 -: AW] != '0) begin
        e.we = 1'b1;
        e.wa = head[AW+DW-1 -: AW];
        e.wd = head[DW-1:0];
      end
    end else if (pipe) begin
      e.we = 1'b1;
      e.wa = wreg;
      e.wd = res;
    end
    sb_q.push_back(e);
    if (forcing) begin
      if (mq.size() == 0) begin
        forcing = 0;
        age     = 0;
      end
    end else if (pop) begin
      age = 0;
    end else if (mq.size() > 0) begin
      if (age == LIMIT - 1) forcing = 1;
      else                  age++;
    end
    if (lv && e.ready) mq.push_back({lreg, ldata});
  endtask

  // Asynchronous reset in mid-cycle; outputs must drop at once.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reg_write_w = 1'b1; write_reg_w = 5'd7; result_w = 32'h1234;
    long_valid  = 1'b1; long_reg    = 5'd8; long_data = 32'h5678;
    rst_n = 1'b0;
    #1;
    check("rst_rf_we",   64'(rf_we),        64'd0);
    check("rst_rf_wa",   64'(rf_wa),        64'd0);
    check("rst_rf_wd",   64'(rf_wd),        64'd0);
    check("rst_stall",   64'(stall_wb),     64'd0);
    check("rst_ready",   64'(long_ready),   64'd1);
    check("rst_pending", 64'(pending_mask), 64'd0);
    mq.delete();
    forcing = 0;
    age     = 0;
    @(posedge clk);
    #3;
    reg_write_w = 1'b0; long_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rf_we",   64'(rf_we),        64'(e.we));
        check("rf_wa",   64'(rf_wa),        64'(e.wa));
        check("rf_wd",   64'(rf_wd),        64'(e.wd));
        check("stall",   64'(stall_wb),     64'(e.stall));
        check("ready",   64'(long_ready),   64'(e.ready));
        check("pending", 64'(pending_mask), 64'(e.mask));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wr;
    logic [AW-1:0] lr;
    rst_n = 1'b0;
    reg_write_w = 1'b0; write_reg_w = '0; result_w  = '0;
    long_valid  = 1'b0; long_reg    = '0; long_data = '0;
    age = 0; forcing = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Idle pipeline: queued result written on the next cycle.
    cyc(0, 0, 0, 1, 5'd9, 32'hDEAD);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Simultaneous pipeline and long result: pipeline first.
    cyc(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Continuous pipeline writes starve one queued entry into a forced drain.
    cyc(0, 0, 0, 1, 5'd7, 32'h77);
    repeat (8) cyc(1, 5'd2, 32'hAB, 0, 0, 0);
    // Fill the queue, offer a third, then pop-with-push.
    cyc(1, 5'd1, 32'hA1, 1, 5'd10, 32'h100);
    cyc(1, 5'd1, 32'hA2, 1, 5'd11, 32'h110);
    cyc(1, 5'd1, 32'hA3, 1, 5'd12, 32'h120);
    cyc(0, 0, 0, 1, 5'd13, 32'h130);
    cyc(0, 0, 0, 1, 5'd14, 32'h140);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    // Pipeline write to $0 does not block the queue; queued $0 pops silently.
    cyc(0, 0, 0, 1, 5'd5, 32'h55);
    cyc(1, 5'd0, 32'hFF, 0, 0, 0);
    cyc(0, 0, 0, 1, 5'd0, 32'h99);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Reach the forced drain with entries queued, then reset.
    cyc(1, 5'd1, 32'h1, 1, 5'd20, 32'h200);
    cyc(1, 5'd2, 32'h2, 1, 5'd21, 32'h210);
    repeat (4) cyc(1, 5'd3, 32'h3, 1, 5'd22, 32'h220);
    do_reset();
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    // Randomized traffic, biased toward busy writeback to exercise starvation.
    for (int i = 0; i < 500; i++) begin
      wr = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
      lr = ($urandom_range(0, 6) == 0) ? '0 : AW'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), wr, $urandom,
          1'($urandom_range(0, 2) != 0), lr, $urandom);
      if (i == 250) do_reset();
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
